// File: rtl/rv32_pkg.sv
// Shared RV32 front-end types: XLEN, instruction size, buffer entry and fetch FSM encoding.
package rv32_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            err;
  } fetch_entry_t;

  typedef enum logic {FC_RUN, FC_FAULT} fetch_ctrl_state_e;
endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO of fetch entries with a single-cycle flush; head is registered storage, no bypass.
module fetch_buf
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: consumers gate the head with count != 0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_ctrl.sv
// RV32 fetch sequencer: owns the PC, issues credit-limited I-cache requests, buffers responses for decode.
module fetch_ctrl
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redir_i,
  input  logic [31:0] redir_pc_i,
  output logic        ic_req_valid_o,
  input  logic        ic_req_ready_i,
  output logic [31:0] ic_req_addr_o,
  input  logic        ic_rsp_valid_i,
  input  logic [31:0] ic_rsp_data_i,
  input  logic        ic_rsp_err_i,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output logic [31:0] dec_instr_o,
  output logic [31:0] dec_pc_o,
  output logic        dec_err_o,
  output logic [31:0] pc_q_o
);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [31:0]       pc_q;
  logic [31:0]       rsp_pc_q;
  fetch_ctrl_state_e state_q;
  logic [CW-1:0]     outst_q;
  logic [CW-1:0]     drop_q;
  logic [CW-1:0]     outst_n;
  logic [CW-1:0]     buf_cnt;
  logic              credit_ok;
  logic              accept;
  logic              push;
  logic              pop;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;
  logic [31:0]       redir_pc;

  assign redir_pc   = redir_pc_i & ~32'd3;
  // Each in-flight request already owns a buffer slot, so responses never need backpressure.
  assign credit_ok  = ({1'b0, outst_q} + {1'b0, buf_cnt}) < (CW + 1)'(BUF_DEPTH);
  assign ic_req_valid_o = rst && (state_q == FC_RUN) && !redir_i && credit_ok;
  assign ic_req_addr_o  = pc_q;
  assign pc_q_o         = pc_q;
  assign accept     = ic_req_valid_o && ic_req_ready_i;
  assign push       = ic_rsp_valid_i && !redir_i && (drop_q == '0);
  assign outst_n    = outst_q + CW'(accept) - CW'(ic_rsp_valid_i);
  assign push_entry = '{instr: ic_rsp_data_i, pc: rsp_pc_q, err: ic_rsp_err_i};

  assign dec_valid_o = (buf_cnt != '0);
  assign dec_instr_o = dec_valid_o ? head.instr : '0;
  assign dec_pc_o    = dec_valid_o ? head.pc    : '0;
  assign dec_err_o   = dec_valid_o && head.err;
  assign pop         = dec_valid_o && dec_ready_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      state_q  <= FC_RUN;
      outst_q  <= '0;
      drop_q   <= '0;
    end else begin
      outst_q <= outst_n;
      if (redir_i) begin
        // Everything still in flight after this cycle belongs to the old path.
        pc_q     <= redir_pc;
        rsp_pc_q <= redir_pc;
        state_q  <= FC_RUN;
        drop_q   <= outst_n;
      end else begin
        if (accept) pc_q <= pc_q + 32'(INSTR_BYTES);
        if (ic_rsp_valid_i && (drop_q != '0)) drop_q <= drop_q - CW'(1);
        if (push) begin
          rsp_pc_q <= rsp_pc_q + 32'(INSTR_BYTES);
          if (ic_rsp_err_i) state_q <= FC_FAULT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && ic_rsp_valid_i) assert (outst_q != '0);
  end

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (redir_i),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (buf_cnt)
  );
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a one-cycle in-order I-cache model and a decode recorder.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        redir_i;
  logic [31:0] redir_pc_i;
  logic        ic_req_valid_o;
  logic        ic_req_ready_i;
  logic [31:0] ic_req_addr_o;
  logic        ic_rsp_valid_i;
  logic [31:0] ic_rsp_data_i;
  logic        ic_rsp_err_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_instr_o;
  logic [31:0] dec_pc_o;
  logic        dec_err_o;
  logic [31:0] pc_q_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] pend[$];
  logic [31:0] accq[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];
  logic        got_err[$];
  bit          rsp_en;
  bit          err_en;
  logic [31:0] err_addr;
  int          n;

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .redir_i        (redir_i),
    .redir_pc_i     (redir_pc_i),
    .ic_req_valid_o (ic_req_valid_o),
    .ic_req_ready_i (ic_req_ready_i),
    .ic_req_addr_o  (ic_req_addr_o),
    .ic_rsp_valid_i (ic_rsp_valid_i),
    .ic_rsp_data_i  (ic_rsp_data_i),
    .ic_rsp_err_i   (ic_rsp_err_i),
    .dec_valid_o    (dec_valid_o),
    .dec_ready_i    (dec_ready_i),
    .dec_instr_o    (dec_instr_o),
    .dec_pc_o       (dec_pc_o),
    .dec_err_o      (dec_err_o),
    .pc_q_o         (pc_q_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic tick();
    logic acc;
    logic [31:0] a;
    logic popd;
    ic_rsp_valid_i = rsp_en && (pend.size() > 0);
    ic_rsp_data_i  = ic_rsp_valid_i ? instr_of(pend[0]) : 32'h0;
    ic_rsp_err_i   = ic_rsp_valid_i && err_en && (pend[0] == err_addr);
    #1;
    acc  = ic_req_valid_o && ic_req_ready_i;
    a    = ic_req_addr_o;
    popd = rst && dec_valid_o && dec_ready_i;
    if (popd) begin
      got_pc.push_back(dec_pc_o);
      got_instr.push_back(dec_instr_o);
      got_err.push_back(dec_err_o);
    end
    @(posedge clk);
    if (!rst) begin
      pend.delete();
    end else begin
      if (ic_rsp_valid_i) void'(pend.pop_front());
      if (acc) begin
        pend.push_back(a);
        accq.push_back(a);
      end
    end
    @(negedge clk);
    ic_rsp_valid_i = 1'b0;
  endtask

  task automatic clear_got();
    got_pc.delete();
    got_instr.delete();
    got_err.delete();
  endtask

  initial begin
    rst = 1'b0; redir_i = 1'b0; redir_pc_i = 32'h0;
    ic_req_ready_i = 1'b1; ic_rsp_valid_i = 1'b0; ic_rsp_data_i = 32'h0; ic_rsp_err_i = 1'b0;
    dec_ready_i = 1'b0; rsp_en = 1'b1; err_en = 1'b0; err_addr = 32'h0;
    @(negedge clk);
    tick(); tick();
    check("rst_req_valid", 32'(ic_req_valid_o), 32'd0);
    check("rst_dec_valid", 32'(dec_valid_o), 32'd0);
    check("rst_dec_instr", dec_instr_o, 32'h0);
    check("rst_dec_pc", dec_pc_o, 32'h0);
    check("rst_dec_err", 32'(dec_err_o), 32'd0);
    check("rst_pc", pc_q_o, 32'h0);

    // Stream from reset with decode stalled: two issues, then credit stall.
    rst = 1'b1;
    tick();
    check("t1_pc_after_first", pc_q_o, 32'h4);
    tick();
    check("t1_dec_valid", 32'(dec_valid_o), 32'd1);
    check("t1_dec_pc", dec_pc_o, 32'h0);
    check("t1_dec_instr", dec_instr_o, instr_of(32'h0));
    tick(); tick();
    check("t2_stall_req_valid", 32'(ic_req_valid_o), 32'd0);
    check("t1_acc_count", 32'(accq.size()), 32'd2);
    check("t1_acc0", q_at(accq, 0), 32'h0);
    check("t1_acc1", q_at(accq, 1), 32'h4);
    check("t1_pc_stalled", pc_q_o, 32'h8);

    // Release decode: one pop per cycle, then issue resumes at 8.
    dec_ready_i = 1'b1;
    tick();
    check("t2_dec_pc_after_pop", dec_pc_o, 32'h4);
    tick();
    rsp_en = 1'b0;
    tick(); tick();
    check("t2_pop_count", 32'(got_pc.size()), 32'd2);
    check("t2_pop_pc1", q_at(got_pc, 1), 32'h4);
    check("t2_resume_addr", q_at(accq, 2), 32'h8);
    check("t2_acc3", q_at(accq, 3), 32'hC);
    check("t3_inflight_stall", 32'(ic_req_valid_o), 32'd0);

    // Redirect with two requests in flight.
    redir_i = 1'b1; redir_pc_i = 32'h0000_1003;
    tick();
    redir_i = 1'b0; rsp_en = 1'b1;
    clear_got(); n = accq.size();
    tick(); tick();
    check("t3_dropped_empty", 32'(dec_valid_o), 32'd0);
    check("t3_no_pop", 32'(got_pc.size()), 32'd0);
    tick(); tick(); tick(); tick();
    check("t3_next_addr", q_at(accq, n), 32'h0000_1000);
    check("t3_first_dec_pc", q_at(got_pc, 0), 32'h0000_1000);
    check("t3_first_dec_instr", q_at(got_instr, 0), instr_of(32'h0000_1000));

    // PC wrap at the top of the address space.
    redir_i = 1'b1; redir_pc_i = 32'hFFFF_FFFC;
    tick();
    redir_i = 1'b0;
    clear_got(); n = accq.size();
    repeat (6) tick();
    check("t4_acc_top", q_at(accq, n), 32'hFFFF_FFFC);
    check("t4_acc_wrap", q_at(accq, n + 1), 32'h0);
    check("t4_dec_pc_top", q_at(got_pc, 0), 32'hFFFF_FFFC);
    check("t4_dec_pc_wrap", q_at(got_pc, 1), 32'h0);
    check("t4_dec_instr_wrap", q_at(got_instr, 1), instr_of(32'h0));

    // Access fault at pc 8 halts issue until a redirect.
    err_en = 1'b1; err_addr = 32'h8;
    redir_i = 1'b1; redir_pc_i = 32'h0;
    tick();
    redir_i = 1'b0;
    clear_got();
    repeat (8) tick();
    check("t5_pc0", q_at(got_pc, 0), 32'h0);
    check("t5_err0", 32'(got_err.size() > 0 ? got_err[0] : 1'b1), 32'd0);
    check("t5_err_pc", q_at(got_pc, 2), 32'h8);
    check("t5_err_flag", 32'(got_err.size() > 2 ? got_err[2] : 1'b0), 32'd1);
    n = accq.size();
    repeat (5) tick();
    check("t5_no_more_acc", 32'(accq.size()), 32'(n));
    check("t5_req_valid_fault", 32'(ic_req_valid_o), 32'd0);
    err_en = 1'b0;
    redir_i = 1'b1; redir_pc_i = 32'h0000_0200;
    tick();
    redir_i = 1'b0;
    clear_got(); n = accq.size();
    repeat (4) tick();
    check("t5_resume_addr", q_at(accq, n), 32'h0000_0200);
    check("t5_resume_dec_pc", q_at(got_pc, 0), 32'h0000_0200);

    // Reset with the buffer full.
    dec_ready_i = 1'b0;
    repeat (4) tick();
    check("t6_full_dec_valid", 32'(dec_valid_o), 32'd1);
    check("t6_full_req_valid", 32'(ic_req_valid_o), 32'd0);
    rst = 1'b0;
    tick();
    check("t6_rst_req_valid", 32'(ic_req_valid_o), 32'd0);
    check("t6_rst_dec_valid", 32'(dec_valid_o), 32'd0);
    check("t6_rst_dec_instr", dec_instr_o, 32'h0);
    check("t6_rst_dec_pc", dec_pc_o, 32'h0);
    check("t6_rst_dec_err", 32'(dec_err_o), 32'd0);
    check("t6_rst_pc", pc_q_o, 32'h0);
    rst = 1'b1; dec_ready_i = 1'b1;
    clear_got(); n = accq.size();
    repeat (4) tick();
    check("t6_first_addr", q_at(accq, n), 32'h0);
    check("t6_first_dec_pc", q_at(got_pc, 0), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
